// File: rtl/dmem_responder.sv
// dmem_responder: data memory behind the cs/oe/rw strobes, with WAIT wait states.
// Completion raises a one-cycle ready pulse; illegal strobes raise a one-cycle err.
module dmem_responder #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              oe,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              err
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    localparam bit         NO_WAIT = (WAIT == 0);
    localparam logic [3:0] WAIT_M1 = NO_WAIT ? 4'd0 : 4'(WAIT - 1);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_rd;
    logic [DATA_W-1:0] r_rdata;
    logic              r_ready;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    logic              w_rd_req;
    logic              w_wr_req;
    logic              w_bad;
    logic              w_start;
    logic              w_enter;
    logic              w_op_rd;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_rd_req = !cs && !oe && rw;
    assign w_wr_req = !cs && oe && !rw;
    assign w_bad    = !cs && (oe == rw);
    assign w_start  = (r_state == S_IDLE) && (w_rd_req || w_wr_req);

    // With no wait states the access completes straight from IDLE,
    // so the array port takes the live inputs instead of the latched copies.
    assign w_enter = (w_start && NO_WAIT)
                   || ((r_state == S_BUSY) && (r_cnt == 4'd0));
    assign w_op_rd = (r_state == S_IDLE) ? w_rd_req : r_is_rd;
    assign w_addr  = (r_state == S_IDLE) ? addr : r_addr;
    assign w_data  = (r_state == S_IDLE) ? wdata : r_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_is_rd <= 1'b0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            if (w_enter && w_op_rd) begin
                r_rdata <= r_mem[w_addr];
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_bad) begin
                        r_err <= 1'b1;
                    end else if (w_start) begin
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_is_rd <= w_rd_req;
                        r_cnt   <= WAIT_M1;
                        if (NO_WAIT) begin
                            r_state <= S_DONE;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_DONE;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_enter && !w_op_rd) begin
            r_mem[w_addr] <= w_data;
        end
    end

    assign rdata = r_rdata;
    assign ready = r_ready;
    assign err   = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT = 2, 0, 3) driven by
// a vector table, hand-written corner sequences and a random run vs. a model.
module tb_dmem_responder;
    logic        clk;
    logic        rst_n;
    logic        cs    [3];
    logic        oe    [3];
    logic        rw    [3];
    logic [6:0]  addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        ready [3];
    logic        err   [3];

    int wv [3] = '{2, 0, 3};
    int total = 0;
    int bad   = 0;

    logic [31:0] mm    [3][16];
    bit          kn    [3][16];
    logic [31:0] lastv [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WV = (g == 0) ? 2 : ((g == 1) ? 0 : 3);
        dmem_responder #(
            .ADDR_W(7),
            .DATA_W(32),
            .WAIT  (WV)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .cs   (cs[g]),
            .oe   (oe[g]),
            .rw   (rw[g]),
            .addr (addr[g]),
            .wdata(wdata[g]),
            .rdata(rdata[g]),
            .ready(ready[g]),
            .err  (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the following IDLE cycle
    // unless hold is set, in which case it returns in the ready cycle.
    task automatic access(input int i, input bit rd, input logic [6:0] a,
                          input logic [31:0] d, input logic [31:0] exp,
                          input bit glitch, input bit hold);
        int n;
        bit eseen;
        n = 0;
        eseen = 0;
        cs[i] = 1'b0;
        oe[i] = !rd;
        rw[i] = rd;
        addr[i] = a;
        wdata[i] = d;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (err[i]) eseen = 1;
            if (ready[i]) break;
            if (glitch && n == 1) begin
                addr[i] = addr[i] + 7'd1;
                rw[i] = 1'b0;
                oe[i] = 1'b1;
                wdata[i] = 32'hFFFF_FFFF;
            end
        end
        chk($sformatf("lat%0d a=%h", i, a), 64'(n), 64'(wv[i] + 1));
        chk($sformatf("rdata%0d a=%h", i, a), 64'(rdata[i]), 64'(exp));
        chk($sformatf("noerr%0d", i), 64'(eseen), 64'd0);
        if (!hold) begin
            cs[i] = 1'b1;
            @(negedge clk);
            chk($sformatf("rdyoff%0d", i), 64'(ready[i]), 64'd0);
        end
    endtask

    task automatic illegal(input int i, input bit v);
        cs[i] = 1'b0;
        oe[i] = v;
        rw[i] = v;
        @(negedge clk);
        chk($sformatf("err%0d", i), {62'd0, err[i], ready[i]}, 64'd2);
        cs[i] = 1'b1;
        @(negedge clk);
        chk($sformatf("errclr%0d", i), {62'd0, err[i], ready[i]}, 64'd0);
        chk($sformatf("rdhold%0d", i), 64'(rdata[i]), 64'(lastv[i]));
    endtask

    typedef struct {
        int          i;
        bit          rd;
        logic [6:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tv [9];

    initial begin
        int n;
        bit seen;
        tv[0] = '{0, 1'b0, 7'h05, 32'hDEADBEEF, 32'h0};
        tv[1] = '{0, 1'b1, 7'h05, 32'h0,        32'hDEADBEEF};
        tv[2] = '{0, 1'b0, 7'h10, 32'hCAFEF00D, 32'hDEADBEEF};
        tv[3] = '{0, 1'b0, 7'h11, 32'h55AA55AA, 32'hDEADBEEF};
        tv[4] = '{0, 1'b1, 7'h10, 32'h0,        32'hCAFEF00D};
        tv[5] = '{0, 1'b1, 7'h05, 32'h0,        32'hDEADBEEF};
        tv[6] = '{2, 1'b0, 7'h03, 32'h11111111, 32'h0};
        tv[7] = '{2, 1'b1, 7'h03, 32'h0,        32'h11111111};
        tv[8] = '{1, 1'b0, 7'h20, 32'h0F0F0F0F, 32'h0};

        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cs[i] = 1'b1;
            oe[i] = 1'b1;
            rw[i] = 1'b1;
            addr[i] = '0;
            wdata[i] = '0;
        end

        // Reset asserted mid-cycle, then idle with cs high.
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++)
                chk($sformatf("rst%0d c%0d", i, c),
                    {30'd0, ready[i], err[i], rdata[i]}, 64'd0);
        end

        for (int k = 0; k < 9; k++)
            access(tv[k].i, tv[k].rd, tv[k].a, tv[k].d, tv[k].exp, 0, 0);

        // WAIT=0 back-to-back: write held, then read issued right after ready.
        access(1, 0, 7'h7F, 32'h12345678, 32'h0, 0, 1);
        cs[1] = 1'b0;
        oe[1] = 1'b0;
        rw[1] = 1'b1;
        @(negedge clk);
        chk("b2b gap", 64'(ready[1]), 64'd0);
        @(negedge clk);
        chk("b2b rdy", 64'(ready[1]), 64'd1);
        chk("b2b rdata", 64'(rdata[1]), 64'h12345678);
        cs[1] = 1'b1;
        @(negedge clk);

        // Reset in the middle of a WAIT=3 write.
        cs[2] = 1'b0;
        oe[2] = 1'b1;
        rw[2] = 1'b0;
        addr[2] = 7'h03;
        wdata[2] = 32'hAAAA5555;
        seen = 0;
        @(negedge clk);
        if (ready[2]) seen = 1;
        @(negedge clk);
        if (ready[2]) seen = 1;
        rst_n = 1'b0;
        cs[2] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ready[2]) seen = 1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ready[2]) seen = 1;
        end
        chk("abort noready", 64'(seen), 64'd0);
        chk("abort rdata0", 64'(rdata[2]), 64'd0);
        access(2, 1, 7'h03, 32'h0, 32'h11111111, 0, 0);

        // Inputs change during BUSY; latched read of 0x10 must win.
        access(0, 1, 7'h10, 32'h0, 32'hCAFEF00D, 1, 0);
        access(0, 1, 7'h11, 32'h0, 32'h55AA55AA, 0, 0);

        lastv[0] = 32'h55AA55AA;
        illegal(0, 1'b0);
        illegal(0, 1'b1);

        // Random traffic against a per-instance array model.
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 16; j++) kn[i][j] = 0;
            mm[i][0] = $urandom;
            kn[i][0] = 1;
            access(i, 0, 7'h40, mm[i][0], rdata[i] === 32'h0 ? 32'h0 : rdata[i], 0, 0);
            access(i, 1, 7'h40, 32'h0, mm[i][0], 0, 0);
            lastv[i] = mm[i][0];
        end
        for (int t = 0; t < 80; t++) begin
            int i;
            int op;
            int j;
            logic [31:0] d;
            i = $urandom_range(0, 2);
            op = $urandom_range(0, 5);
            j = $urandom_range(0, 15);
            if (op >= 2 && op <= 3 && !kn[i][j]) op = 0;
            if (op <= 1) begin
                d = $urandom;
                access(i, 0, 7'(8'h40 + j), d, lastv[i], 0, 0);
                mm[i][j] = d;
                kn[i][j] = 1;
            end else if (op <= 3) begin
                access(i, 1, 7'(8'h40 + j), 32'h0, mm[i][j], 0, 0);
                lastv[i] = mm[i][j];
            end else if (op == 4) begin
                illegal(i, 1'($urandom_range(0, 1)));
            end else begin
                addr[i] = 7'($urandom);
                oe[i] = 1'($urandom);
                rw[i] = 1'($urandom);
                @(negedge clk);
                chk($sformatf("idle%0d", i),
                    {30'd0, ready[i], err[i], rdata[i]},
                    {32'd0, lastv[i]});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
